// File: rtl/spi_regfile_pkg.sv
// Shared definitions for the SPI register-file peripheral: FSM encoding,
// R/W flag values, frame-width helper and the output-enable mux register map.
package spi_regfile_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    // Registers 0..3 drive PWM duty, the last one selects output enables.
    localparam int unsigned ADDR_OE_MUX  = 4;
    localparam int unsigned REG_MAP_SIZE = ADDR_OE_MUX + 1;

    function automatic int unsigned frame_w(input int unsigned addr_w, input int unsigned data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin plus rise/fall detection
// on the synchronised level; reset level is a parameter so idle-high pins work.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // NOTE: non-blocking assignments make the three flops a true pipeline;
    // blocking ones would collapse it into a single stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
            r_prev <= RST_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_rise  = r_sync & ~r_prev;
    assign o_fall  = ~r_sync & r_prev;

endmodule

// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 peripheral with NUM_REGS x DATA_W read/write control registers,
// per-register write strobes and short/long frame error reporting.
module spi_regfile_peripheral
    import spi_regfile_pkg::*;
#(
    parameter int unsigned       NUM_REGS  = REG_MAP_SIZE,
    parameter int unsigned       ADDR_W    = 7,
    parameter int unsigned       DATA_W    = 8,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         SCLK,
    input  logic                         nCS,
    input  logic                         COPI,
    output logic                         CIPO,
    output logic                         cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0]   regs_out,
    output logic [NUM_REGS-1:0]          wr_stb,
    output logic                         frame_err
);

    localparam int unsigned FRAME_W = frame_w(ADDR_W, DATA_W);
    localparam int unsigned CNT_W   = $clog2(FRAME_W);
    localparam int unsigned IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_W:0] NUM_REGS_A = (ADDR_W + 1)'(NUM_REGS);

    logic w_sclk_level, w_sclk_rise, w_sclk_fall;
    logic w_ncs_level, w_ncs_rise, w_ncs_fall;
    logic w_copi, w_copi_rise, w_copi_fall;
    logic w_unused;

    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .i_async(SCLK),
        .o_level(w_sclk_level), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );
    spi_sync_edge #(.RST_VAL(1'b1)) u_sync_ncs (
        .clk(clk), .rst_n(rst_n), .i_async(nCS),
        .o_level(w_ncs_level), .o_rise(w_ncs_rise), .o_fall(w_ncs_fall)
    );
    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_copi (
        .clk(clk), .rst_n(rst_n), .i_async(COPI),
        .o_level(w_copi), .o_rise(w_copi_rise), .o_fall(w_copi_fall)
    );

    assign w_unused = &{1'b0, w_sclk_level, w_ncs_rise, w_copi_rise, w_copi_fall};

    state_t              r_state;
    logic [CNT_W-1:0]    r_bit_cnt;
    logic [ADDR_W-1:0]   r_hdr;
    logic [DATA_W-2:0]   r_data;
    logic [DATA_W-2:0]   r_tx;
    logic                r_rw;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_extra;
    logic                r_cipo;
    logic                r_frame_err;
    logic [NUM_REGS-1:0] r_wr_stb;
    logic [DATA_W-1:0]   r_regs [NUM_REGS];

    logic [ADDR_W:0]   w_hdr_next;
    logic [DATA_W-1:0] w_data_next;
    logic              w_rd_in_range, w_wr_in_range;
    logic [IDX_W-1:0]  w_rd_idx, w_wr_idx;
    logic [DATA_W-1:0] w_rd_val;

    assign w_hdr_next    = {r_hdr, w_copi};
    assign w_data_next   = {r_data, w_copi};
    assign w_rd_in_range = {1'b0, w_hdr_next[ADDR_W-1:0]} < NUM_REGS_A;
    assign w_rd_idx      = w_hdr_next[IDX_W-1:0];
    assign w_wr_in_range = {1'b0, r_addr} < NUM_REGS_A;
    assign w_wr_idx      = r_addr[IDX_W-1:0];

    // NOTE: default assignment first so every path drives w_rd_val (no latch).
    always_comb begin
        w_rd_val = '0;
        if (w_rd_in_range) w_rd_val = r_regs[w_rd_idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= '0;
            r_hdr       <= '0;
            r_data      <= '0;
            r_tx        <= '0;
            r_rw        <= RW_READ;
            r_addr      <= '0;
            r_extra     <= 1'b0;
            r_cipo      <= 1'b0;
            r_frame_err <= 1'b0;
            r_wr_stb    <= '0;
            // NOTE: the register array is a handful of control flops, so it is
            // reset explicitly; a RAM-style array would be left unreset.
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= RESET_VAL;
        end else begin
            r_wr_stb    <= '0;
            r_frame_err <= 1'b0;
            if (w_ncs_fall) begin
                r_state   <= ST_HDR;
                r_bit_cnt <= '0;
                r_hdr     <= '0;
                r_data    <= '0;
                r_tx      <= '0;
                r_extra   <= 1'b0;
                r_cipo    <= 1'b0;
            end else if (w_ncs_level && r_state != ST_IDLE) begin
                r_frame_err <= (r_state != ST_DONE) || r_extra;
                r_state     <= ST_IDLE;
                r_cipo      <= 1'b0;
            end else begin
                unique case (r_state)
                    ST_HDR: begin
                        if (w_sclk_rise) begin
                            r_hdr <= w_hdr_next[ADDR_W-1:0];
                            if (r_bit_cnt == CNT_W'(ADDR_W)) begin
                                r_state   <= ST_DATA;
                                r_bit_cnt <= '0;
                                r_rw      <= w_hdr_next[ADDR_W];
                                r_addr    <= w_hdr_next[ADDR_W-1:0];
                                if (w_hdr_next[ADDR_W] == RW_READ) begin
                                    r_cipo <= w_rd_val[DATA_W-1];
                                    r_tx   <= w_rd_val[DATA_W-2:0];
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                            end
                        end
                    end
                    ST_DATA: begin
                        if (w_sclk_rise) begin
                            r_data <= w_data_next[DATA_W-2:0];
                            if (r_bit_cnt == CNT_W'(DATA_W - 1)) begin
                                r_state <= ST_DONE;
                                if (r_rw == RW_WRITE && w_wr_in_range) begin
                                    r_regs[w_wr_idx]   <= w_data_next;
                                    r_wr_stb[w_wr_idx] <= 1'b1;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                            end
                        // The fall right after the header's last rise must keep the MSB on CIPO.
                        end else if (w_sclk_fall && r_rw == RW_READ && r_bit_cnt != '0) begin
                            r_cipo <= r_tx[DATA_W-2];
                            r_tx   <= {r_tx[DATA_W-3:0], 1'b0};
                        end
                    end
                    ST_DONE: begin
                        if (w_sclk_rise) r_extra <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
        assign regs_out[g*DATA_W +: DATA_W] = r_regs[g];
    end

    assign CIPO      = r_cipo;
    assign cipo_oe   = ~w_ncs_level;
    assign wr_stb    = r_wr_stb;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// Self-checking bench for spi_regfile_peripheral: directed frames followed by
// random frames, all checked against a register-array reference model.
module tb_spi_regfile_peripheral;

    localparam int NUM_REGS = 5;
    localparam int ADDR_W   = 7;
    localparam int DATA_W   = 8;

    logic                       clk   = 1'b0;
    logic                       rst_n = 1'b0;
    logic                       SCLK  = 1'b0;
    logic                       nCS   = 1'b1;
    logic                       COPI  = 1'b0;
    logic                       CIPO;
    logic                       cipo_oe;
    logic [NUM_REGS*DATA_W-1:0] regs_out;
    logic [NUM_REGS-1:0]        wr_stb;
    logic                       frame_err;

    spi_regfile_peripheral #(
        .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_VAL(8'h00)
    ) dut (
        .clk(clk), .rst_n(rst_n), .SCLK(SCLK), .nCS(nCS), .COPI(COPI),
        .CIPO(CIPO), .cipo_oe(cipo_oe), .regs_out(regs_out),
        .wr_stb(wr_stb), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    int          stb_cnt [NUM_REGS];
    int          ferr_cnt;
    int          cipo_hi;
    bit          in_frame = 1'b0;
    logic [7:0]  model   [NUM_REGS];

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) if (wr_stb[i]) stb_cnt[i]++;
            if (frame_err) ferr_cnt++;
            if (in_frame && CIPO) cipo_hi++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, output logic sampled);
        COPI = b;
        wait_clk(4);
        sampled = CIPO;
        SCLK = 1'b1;
        wait_clk(8);
        SCLK = 1'b0;
        wait_clk(4);
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < NUM_REGS; i++)
            check($sformatf("%s_reg%0d", tag, i), regs_out[i*DATA_W +: DATA_W], model[i]);
    endtask

    task automatic do_frame(input string tag, input logic rw, input logic [6:0] addr,
                            input logic [7:0] data, input int nbits);
        logic [15:0] frame;
        logic [7:0]  rd;
        logic [7:0]  exp_rd;
        logic        s;
        int          exp_stb [NUM_REGS];
        frame = {rw, addr, data};
        rd    = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            stb_cnt[i] = 0;
            exp_stb[i] = 0;
        end
        ferr_cnt = 0;
        cipo_hi  = 0;
        exp_rd   = (int'(addr) < NUM_REGS) ? model[addr] : 8'h00;

        nCS = 1'b0;
        in_frame = 1'b1;
        wait_clk(6);
        check({tag, "_oe_on"}, cipo_oe, 1'b1);
        for (int i = 0; i < nbits; i++) begin
            send_bit((i < 16) ? frame[15-i] : 1'b0, s);
            if (i >= 8 && i < 16) rd[15-i] = s;
        end
        wait_clk(2);
        in_frame = 1'b0;
        nCS = 1'b1;
        wait_clk(8);

        if (nbits >= 16 && rw && int'(addr) < NUM_REGS) begin
            model[addr]   = data;
            exp_stb[addr] = 1;
        end
        check_regs(tag);
        for (int i = 0; i < NUM_REGS; i++)
            check($sformatf("%s_stb%0d", tag, i), stb_cnt[i], exp_stb[i]);
        check({tag, "_ferr"}, ferr_cnt, (nbits != 16) ? 1 : 0);
        check({tag, "_oe_off"}, cipo_oe, 1'b0);
        if (rw) check({tag, "_cipo_quiet"}, cipo_hi, 0);
        else if (nbits >= 16) check({tag, "_rdata"}, rd, exp_rd);
    endtask

    initial begin
        logic s;
        for (int i = 0; i < NUM_REGS; i++) model[i] = 8'h00;

        wait_clk(3);
        check("rst_regs", regs_out, '0);
        check("rst_stb", wr_stb, '0);
        check("rst_ferr", frame_err, 1'b0);
        check("rst_cipo", CIPO, 1'b0);
        check("rst_oe", cipo_oe, 1'b0);
        rst_n = 1'b1;
        wait_clk(4);

        do_frame("wr4", 1'b1, 7'h04, 8'hA5, 16);
        do_frame("rd4", 1'b0, 7'h04, 8'h00, 16);
        do_frame("wr_oor", 1'b1, 7'h10, 8'hFF, 16);
        do_frame("rd_oor", 1'b0, 7'h10, 8'h00, 16);
        do_frame("short", 1'b1, 7'h01, 8'h77, 10);
        do_frame("after_short", 1'b1, 7'h01, 8'h5A, 16);
        do_frame("long", 1'b1, 7'h02, 8'h3C, 17);
        do_frame("rd2", 1'b0, 7'h02, 8'h00, 16);
        do_frame("rd_top", 1'b0, 7'h7F, 8'h00, 16);

        // Reset asserted after eight bits of a write frame.
        nCS = 1'b0;
        wait_clk(6);
        for (int i = 0; i < 8; i++) send_bit((i == 0 || i == 7) ? 1'b1 : 1'b0, s);
        #1 rst_n = 1'b0;
        #1;
        for (int i = 0; i < NUM_REGS; i++) model[i] = 8'h00;
        check_regs("midrst");
        check("midrst_stb", wr_stb, '0);
        check("midrst_oe", cipo_oe, 1'b0);
        check("midrst_cipo", CIPO, 1'b0);
        wait_clk(3);
        nCS  = 1'b1;
        SCLK = 1'b0;
        COPI = 1'b0;
        rst_n = 1'b1;
        wait_clk(6);
        do_frame("post_rst", 1'b1, 7'h03, 8'hC3, 16);

        for (int n = 0; n < 24; n++) begin
            logic       rw;
            logic [6:0] addr;
            logic [7:0] data;
            int         nbits;
            rw   = 1'($urandom_range(0, 1));
            addr = ($urandom_range(0, 5) == 0) ? 7'h7F : 7'($urandom_range(0, 7));
            data = 8'($urandom);
            case ($urandom_range(0, 7))
                0:       nbits = 5;
                1:       nbits = 12;
                2:       nbits = 17;
                default: nbits = 16;
            endcase
            do_frame($sformatf("rnd%0d", n), rw, addr, data, nbits);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
